push_class_vc: RTL and testbench

- Write-side counterpart to the VC pop/arbitration logic.
- Accepts a stream of words from the upstream source and steers each word into the VC0 or VC1 FIFO according to its class bit.
- Holds one word in a registered stage when the target FIFO is full.
- Back-pressures upstream with pause, driven by the FIFO full/almost-full flags.
- Counts words pushed per VC.

---
 rtl/push_class_vc_if.sv | 29 ++
 rtl/push_class_vc.sv | 82 ++++++++
 tb/tb_push_class_vc.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/push_class_vc_if.sv
// rtl/push_class_vc_if.sv - upstream word stream and VC FIFO write-side signals
interface push_class_vc_if #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 5
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  vc0_full;
  logic                  vc1_full;
  logic                  vc0_almost_full;
  logic                  vc1_almost_full;
  logic                  pause;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  vc0_push;
  logic                  vc1_push;
  logic                  drop_err;
  logic [CNT_WIDTH-1:0]  vc0_cnt;
  logic [CNT_WIDTH-1:0]  vc1_cnt;

  modport master (
    output valid_in, data_in, vc0_full, vc1_full, vc0_almost_full, vc1_almost_full,
    input  pause, data_out, vc0_push, vc1_push, drop_err, vc0_cnt, vc1_cnt
  );

  modport slave (
    input  valid_in, data_in, vc0_full, vc1_full, vc0_almost_full, vc1_almost_full,
    output pause, data_out, vc0_push, vc1_push, drop_err, vc0_cnt, vc1_cnt
  );
endinterface

// File: rtl/push_class_vc.sv
// rtl/push_class_vc.sv - steers upstream words into VC0/VC1 FIFOs by class bit
module push_class_vc #(
  parameter int DATA_WIDTH = 6,
  parameter int CLASS_BIT  = 4,
  parameter int CNT_WIDTH  = 5
) (
  input logic           clk,
  input logic           reset_L,
  push_class_vc_if.slave bus
);

  typedef enum logic [1:0] {INIT, ACTIVE, STALL} state_t;

  state_t                state, state_nxt;
  logic                  st_valid, st_valid_nxt;
  logic [DATA_WIDTH-1:0] st_data, st_data_nxt;
  logic                  drop_err_q;
  logic [CNT_WIDTH-1:0]  vc0_cnt_q, vc1_cnt_q;

  logic tgt_full, tgt_full_nxt, drain, accept, pause_c;
  logic push0, push1;

  always_comb begin
    tgt_full = st_data[CLASS_BIT] ? bus.vc1_full : bus.vc0_full;
    push0    = st_valid & ~st_data[CLASS_BIT] & ~bus.vc0_full;
    push1    = st_valid &  st_data[CLASS_BIT] & ~bus.vc1_full;
    drain    = push0 | push1;
    pause_c  = (state == INIT) | (st_valid & tgt_full)
             | bus.vc0_almost_full | bus.vc1_almost_full;
    accept   = bus.valid_in & ~pause_c & (~st_valid | drain);
  end

  always_comb begin
    st_valid_nxt = st_valid;
    st_data_nxt  = st_data;
    if (accept) begin
      st_valid_nxt = 1'b1;
      st_data_nxt  = bus.data_in;
    end else if (drain) begin
      st_valid_nxt = 1'b0;
    end
  end

  // STALL mirrors "staged word blocked by its full target" as seen at the next edge
  always_comb begin
    state_nxt    = state;
    tgt_full_nxt = st_data_nxt[CLASS_BIT] ? bus.vc1_full : bus.vc0_full;
    case (state)
      INIT:    state_nxt = ACTIVE;
      ACTIVE,
      STALL:   state_nxt = (st_valid_nxt & tgt_full_nxt) ? STALL : ACTIVE;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= INIT;
      st_valid   <= 1'b0;
      st_data    <= '0;
      drop_err_q <= 1'b0;
      vc0_cnt_q  <= '0;
      vc1_cnt_q  <= '0;
    end else begin
      state      <= state_nxt;
      st_valid   <= st_valid_nxt;
      st_data    <= st_data_nxt;
      drop_err_q <= bus.valid_in & pause_c;
      if (push0) vc0_cnt_q <= vc0_cnt_q + CNT_WIDTH'(1);
      if (push1) vc1_cnt_q <= vc1_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.pause    = pause_c;
  assign bus.data_out = st_data;
  assign bus.vc0_push = push0;
  assign bus.vc1_push = push1;
  assign bus.drop_err = drop_err_q;
  assign bus.vc0_cnt  = vc0_cnt_q;
  assign bus.vc1_cnt  = vc1_cnt_q;

endmodule

// File: tb/tb_push_class_vc.sv
// tb/tb_push_class_vc.sv - directed self-checking bench for push_class_vc
module tb_push_class_vc;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  push_class_vc_if #(.DATA_WIDTH(6), .CNT_WIDTH(5)) bus ();

  push_class_vc #(.DATA_WIDTH(6), .CLASS_BIT(4), .CNT_WIDTH(5)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_slot();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.valid_in        = 1'b0;
    bus.data_in         = '0;
    bus.vc0_full        = 1'b0;
    bus.vc1_full        = 1'b0;
    bus.vc0_almost_full = 1'b0;
    bus.vc1_almost_full = 1'b0;
  endtask

  logic [5:0] w;

  initial begin
    idle_inputs();

    // reset then idle
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    sample_slot();
    check("rst_pause", bus.pause, 1);
    check("rst_push", {bus.vc0_push, bus.vc1_push}, 0);
    check("rst_data", bus.data_out, 0);
    check("rst_drop", bus.drop_err, 0);
    check("rst_cnt", {bus.vc0_cnt, bus.vc1_cnt}, 0);
    drive_slot();
    reset_L = 1'b1;
    sample_slot();
    check("init_pause", bus.pause, 1);
    drive_slot();
    sample_slot();
    check("active_pause", bus.pause, 0);
    check("idle_push", {bus.vc0_push, bus.vc1_push}, 0);

    // steering, back to back
    drive_slot();
    bus.valid_in = 1'b1; bus.data_in = 6'h05;
    drive_slot();
    bus.data_in = 6'h15;
    sample_slot();
    check("steer0_push", {bus.vc0_push, bus.vc1_push}, 2'b10);
    check("steer0_data", bus.data_out, 6'h05);
    drive_slot();
    bus.valid_in = 1'b0;
    sample_slot();
    check("steer1_push", {bus.vc0_push, bus.vc1_push}, 2'b01);
    check("steer1_data", bus.data_out, 6'h15);
    drive_slot();
    sample_slot();
    check("steer_cnt0", bus.vc0_cnt, 1);
    check("steer_cnt1", bus.vc1_cnt, 1);

    // stall on VC1 full, release after 3 cycles
    bus.vc1_full = 1'b1; bus.valid_in = 1'b1; bus.data_in = 6'h11;
    drive_slot();
    bus.valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_slot();
      check("stall_pause", bus.pause, 1);
      check("stall_push", {bus.vc0_push, bus.vc1_push}, 0);
      drive_slot();
    end
    bus.vc1_full = 1'b0;
    sample_slot();
    check("unstall_push", {bus.vc0_push, bus.vc1_push}, 2'b01);
    check("unstall_data", bus.data_out, 6'h11);
    check("unstall_pause", bus.pause, 0);
    drive_slot();
    sample_slot();
    check("unstall_cnt1", bus.vc1_cnt, 2);
    check("unstall_once", bus.vc1_push, 0);

    // full on the non-target VC does not stall
    bus.vc0_full = 1'b1; bus.valid_in = 1'b1; bus.data_in = 6'h1A;
    drive_slot();
    bus.valid_in = 1'b0;
    sample_slot();
    check("nontgt_push", {bus.vc0_push, bus.vc1_push}, 2'b01);
    check("nontgt_pause", bus.pause, 0);
    drive_slot();
    bus.vc0_full = 1'b0;
    sample_slot();
    check("nontgt_cnt1", bus.vc1_cnt, 3);

    // almost-full backpressure drops the word
    bus.vc0_almost_full = 1'b1; bus.valid_in = 1'b1; bus.data_in = 6'h03;
    sample_slot();
    check("af_pause", bus.pause, 1);
    drive_slot();
    bus.valid_in = 1'b0;
    sample_slot();
    check("af_drop", bus.drop_err, 1);
    check("af_push", {bus.vc0_push, bus.vc1_push}, 0);
    drive_slot();
    sample_slot();
    check("af_drop_once", bus.drop_err, 0);
    check("af_cnt", {bus.vc0_cnt, bus.vc1_cnt}, {5'd1, 5'd3});
    bus.vc1_full = 1'b1;
    sample_slot();
    check("full_af_pause", bus.pause, 1);
    drive_slot();
    idle_inputs();

    // fresh reset, then 32 class-0 words for counter wrap
    reset_L = 1'b0;
    drive_slot();
    reset_L = 1'b1;
    drive_slot();
    for (int i = 0; i <= 32; i++) begin
      w = {i[4], 1'b0, i[3:0]};
      bus.valid_in = (i < 32);
      bus.data_in  = w;
      sample_slot();
      if (i >= 1) begin
        w = {6'(i - 1)};
        w[4] = 1'b0;
        w[5] = 6'(i - 1) >= 6'd16;
        check("wrap_push", {bus.vc0_push, bus.vc1_push}, 2'b10);
        check("wrap_data", bus.data_out, w);
      end
      if (i == 32) check("wrap_cnt31", bus.vc0_cnt, 31);
      drive_slot();
    end
    bus.valid_in = 1'b0;
    sample_slot();
    check("wrap_cnt0", bus.vc0_cnt, 0);
    check("wrap_idle", {bus.vc0_push, bus.vc1_push}, 0);

    // reset while a word is stalled
    drive_slot();
    bus.vc1_full = 1'b1; bus.valid_in = 1'b1; bus.data_in = 6'h14;
    drive_slot();
    bus.valid_in = 1'b0;
    sample_slot();
    check("mid_stall_pause", bus.pause, 1);
    check("mid_stall_data", bus.data_out, 6'h14);
    drive_slot();
    reset_L = 1'b0;
    sample_slot();
    check("mid_rst_data", bus.data_out, 0);
    check("mid_rst_pause", bus.pause, 1);
    bus.vc1_full = 1'b0;
    drive_slot();
    reset_L = 1'b1;
    sample_slot();
    check("post_rst_push_a", {bus.vc0_push, bus.vc1_push}, 0);
    drive_slot();
    sample_slot();
    check("post_rst_push_b", {bus.vc0_push, bus.vc1_push}, 0);
    check("post_rst_cnt", {bus.vc0_cnt, bus.vc1_cnt}, 0);
    check("post_rst_pause", bus.pause, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
